// File: rtl/maxpool_pkg.sv
// Shared definitions for the 2x2/stride-2 max-pool window scheduler.
//   state_e      : scheduler FSM encoding (IDLE, ISSUE, WAIT, FIN)
//   out_side     : output map side for an input side
//   num_windows  : number of output windows for an input side
//   num_batches  : number of lane batches needed to cover every window
package maxpool_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    FIN   = 2'd3
  } state_e;

  function automatic int unsigned out_side(input int unsigned ms);
    return ms / 2;
  endfunction

  function automatic int unsigned num_windows(input int unsigned ms);
    return (ms / 2) * (ms / 2);
  endfunction

  function automatic int unsigned num_batches(input int unsigned ms, input int unsigned lanes);
    return (num_windows(ms) + lanes - 1) / lanes;
  endfunction

endpackage

// File: rtl/maxpool_addr_walker.sv
// Raster walker over the output windows of one feature map.
// Holds the (index, column, row base) of the first window of the next batch to issue and
// derives the top-left address of every window in that batch with a ripple of add/compare
// stages, one per lane, so no multiplier or divider is needed.
// Ports:
//   i_clk, i_reset : clock, asynchronous active-low reset
//   i_load         : restart at window 0 with row base i_base, advancing past the first batch
//   i_step         : advance past the batch currently presented on o_addr/o_valid
//   i_base         : address of pixel (0,0), used only with i_load
//   o_addr         : per-lane window address of the presented batch (0 for lanes with no window)
//   o_valid        : per-lane flag, lane k holds a window in the presented batch
//   o_last         : no windows remain after the most recently issued batch
module maxpool_addr_walker
  import maxpool_pkg::*;
#(
  parameter int unsigned matrix_size = 24,
  parameter int unsigned add_size    = 15,
  parameter int unsigned array_size  = 9
) (
  input  logic                           i_clk,
  input  logic                           i_reset,
  input  logic                           i_load,
  input  logic                           i_step,
  input  logic [add_size-1:0]            i_base,
  output logic [array_size*add_size-1:0] o_addr,
  output logic [array_size-1:0]          o_valid,
  output logic                           o_last
);

  localparam int unsigned OUT  = out_side(matrix_size);
  localparam int unsigned NWIN = num_windows(matrix_size);
  localparam int unsigned CW   = $clog2(OUT + 1);
  localparam int unsigned WW   = $clog2(NWIN + 2 * array_size + 1);

  localparam logic [add_size-1:0] ROW_STEP = add_size'(2 * matrix_size);
  localparam logic [CW-1:0]       COL_LAST = CW'(OUT - 1);
  localparam logic [WW-1:0]       NWIN_W   = WW'(NWIN);

  logic [WW-1:0]       r_idx;
  logic [CW-1:0]       r_col;
  logic [add_size-1:0] r_rb;

  // Running position; after the lane loop these hold the start of the following batch.
  logic [WW-1:0]       w_idx;
  logic [CW-1:0]       w_col;
  logic [add_size-1:0] w_rb;

  always_comb begin
    w_idx   = i_load ? '0 : r_idx;
    w_col   = i_load ? '0 : r_col;
    w_rb    = i_load ? i_base : r_rb;
    o_addr  = '0;
    o_valid = '0;
    for (int k = 0; k < int'(array_size); k++) begin
      o_valid[k] = (w_idx < NWIN_W);
      if (o_valid[k]) begin
        o_addr[k*add_size +: add_size] = w_rb + add_size'({w_col, 1'b0});
      end
      w_idx = w_idx + WW'(1);
      // End of an output row: jump the row base down two input rows.
      if (w_col == COL_LAST) begin
        w_col = '0;
        w_rb  = w_rb + ROW_STEP;
      end else begin
        w_col = w_col + CW'(1);
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_idx <= '0;
      r_col <= '0;
      r_rb  <= '0;
    end else if (i_load || i_step) begin
      r_idx <= w_idx;
      r_col <= w_col;
      r_rb  <= w_rb;
    end
  end

  assign o_last = (r_idx >= NWIN_W);

endmodule

// File: rtl/maxpool_window_scheduler.sv
// Sequences a 2x2/stride-2 max-pool of one matrix_size x matrix_size map over array_size
// fill lanes: issues batches of window top-left addresses, waits for every active lane to
// report done, and pulses o_finish after the last batch.
// Ports:
//   i_clk, i_reset  : clock, asynchronous active-low reset
//   i_start         : begin a map (accepted only when idle)
//   i_abort         : synchronous abort back to idle, no finish pulse
//   i_base_addr     : address of pixel (0,0), sampled on an accepted start
//   o_lane_addr     : per-lane window address, lane i at [(i+1)*add_size-1 : i*add_size]
//   o_lane_go       : one-cycle issue pulse per active lane
//   o_lane_active   : lanes holding a window in the current batch
//   i_lane_done     : per-lane completion (pulse or level)
//   o_busy          : map in progress
//   o_finish        : one-cycle pulse after the last batch completes
module maxpool_window_scheduler
  import maxpool_pkg::*;
#(
  parameter int unsigned matrix_size = 24,
  parameter int unsigned add_size    = 15,
  parameter int unsigned array_size  = 9
) (
  input  logic                           i_clk,
  input  logic                           i_reset,
  input  logic                           i_start,
  input  logic                           i_abort,
  input  logic [add_size-1:0]            i_base_addr,
  output logic [array_size*add_size-1:0] o_lane_addr,
  output logic [array_size-1:0]          o_lane_go,
  output logic [array_size-1:0]          o_lane_active,
  input  logic [array_size-1:0]          i_lane_done,
  output logic                           o_busy,
  output logic                           o_finish
);

  state_e r_state;
  state_e w_state_next;

  logic [array_size*add_size-1:0] r_lane_addr;
  logic [array_size-1:0]          r_lane_active;
  logic [array_size-1:0]          r_done_seen;

  logic [array_size*add_size-1:0] w_walk_addr;
  logic [array_size-1:0]          w_walk_valid;
  logic                           w_last;
  logic                           w_load;
  logic                           w_step;
  logic                           w_clear;
  logic [array_size-1:0]          w_done_new;
  logic                           w_all_done;

  maxpool_addr_walker #(
    .matrix_size (matrix_size),
    .add_size    (add_size),
    .array_size  (array_size)
  ) u_walker (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_load  (w_load),
    .i_step  (w_step),
    .i_base  (i_base_addr),
    .o_addr  (w_walk_addr),
    .o_valid (w_walk_valid),
    .o_last  (w_last)
  );

  // Done from inactive lanes never counts.
  assign w_done_new = i_lane_done & r_lane_active;
  assign w_all_done = ((r_done_seen | w_done_new) == r_lane_active);

  always_comb begin
    w_state_next = r_state;
    w_load       = 1'b0;
    w_step       = 1'b0;
    w_clear      = 1'b0;
    case (r_state)
      IDLE: begin
        if (i_start && !i_abort) begin
          w_load       = 1'b1;
          w_state_next = ISSUE;
        end
      end
      ISSUE: begin
        if (i_abort) begin
          w_clear      = 1'b1;
          w_state_next = IDLE;
        end else begin
          w_state_next = WAIT;
        end
      end
      WAIT: begin
        if (i_abort) begin
          w_clear      = 1'b1;
          w_state_next = IDLE;
        end else if (w_all_done) begin
          if (w_last) begin
            w_clear      = 1'b1;
            w_state_next = FIN;
          end else begin
            w_step       = 1'b1;
            w_state_next = ISSUE;
          end
        end
      end
      FIN: begin
        w_state_next = IDLE;
      end
      default: begin
        w_clear      = 1'b1;
        w_state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_lane_addr   <= '0;
      r_lane_active <= '0;
      r_done_seen   <= '0;
    end else begin
      if (w_load || w_step) begin
        r_lane_addr   <= w_walk_addr;
        r_lane_active <= w_walk_valid;
      end else if (w_clear) begin
        r_lane_addr   <= '0;
        r_lane_active <= '0;
      end
      // Done is only sampled in WAIT so a level held over from the last batch is ignored.
      if (r_state == ISSUE) begin
        r_done_seen <= '0;
      end else if (r_state == WAIT) begin
        r_done_seen <= r_done_seen | w_done_new;
      end
    end
  end

  assign o_lane_addr   = r_lane_addr;
  assign o_lane_active = r_lane_active;
  assign o_lane_go     = (r_state == ISSUE) ? r_lane_active : '0;
  assign o_busy        = (r_state == ISSUE) || (r_state == WAIT);
  assign o_finish      = (r_state == FIN);

endmodule

// File: tb/tb_maxpool_window_scheduler.sv
// Directed bench for maxpool_window_scheduler: two instances (9 and 10 lanes) driven by
// lane responders with programmable done latency; issued batches are logged and compared
// against a raster-order address model.
module tb_maxpool_window_scheduler;

  logic        clk = 1'b0;
  logic        reset;
  logic        start9, start10, abort;
  logic [14:0] base;

  logic [134:0] addr9;
  logic [8:0]   go9, act9, done9, extra9, resp9;
  logic         busy9, fin9;

  logic [149:0] addr10;
  logic [9:0]   go10, act10, done10, extra10, resp10;
  logic         busy10, fin10;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  maxpool_window_scheduler #(
    .matrix_size (24),
    .add_size    (15),
    .array_size  (9)
  ) dut (
    .i_clk         (clk),
    .i_reset       (reset),
    .i_start       (start9),
    .i_abort       (abort),
    .i_base_addr   (base),
    .o_lane_addr   (addr9),
    .o_lane_go     (go9),
    .o_lane_active (act9),
    .i_lane_done   (done9),
    .o_busy        (busy9),
    .o_finish      (fin9)
  );

  maxpool_window_scheduler #(
    .matrix_size (24),
    .add_size    (15),
    .array_size  (10)
  ) dut10 (
    .i_clk         (clk),
    .i_reset       (reset),
    .i_start       (start10),
    .i_abort       (abort),
    .i_base_addr   (base),
    .o_lane_addr   (addr10),
    .o_lane_go     (go10),
    .o_lane_active (act10),
    .i_lane_done   (done10),
    .o_busy        (busy10),
    .o_finish      (fin10)
  );

  // Lane responders: done pulses lat[k] cycles after the lane's go.
  int lat9 [9];
  int lat10 [10];
  int cnt9 [9];
  int cnt10 [10];

  always @(posedge clk) begin
    for (int k = 0; k < 9; k++) begin
      if (go9[k]) cnt9[k] <= lat9[k];
      else if (cnt9[k] > 0) cnt9[k] <= cnt9[k] - 1;
    end
    for (int k = 0; k < 10; k++) begin
      if (go10[k]) cnt10[k] <= lat10[k];
      else if (cnt10[k] > 0) cnt10[k] <= cnt10[k] - 1;
    end
  end

  always_comb begin
    resp9  = '0;
    resp10 = '0;
    for (int k = 0; k < 9; k++) resp9[k] = (cnt9[k] == 1);
    for (int k = 0; k < 10; k++) resp10[k] = (cnt10[k] == 1);
  end

  assign done9  = resp9 | extra9;
  assign done10 = resp10 | extra10;

  // Issue/finish monitors, sampled on the falling edge.
  int gcyc = 0;
  int n9 = 0, n10 = 0, nf9 = 0, nf10 = 0;
  logic [159:0] la9 [256];
  logic [159:0] la10 [256];
  logic [15:0]  lact9 [256];
  logic [15:0]  lgo9 [256];
  logic [15:0]  lact10 [256];
  logic [15:0]  lgo10 [256];
  int           lt9 [256];

  always @(posedge clk) gcyc <= gcyc + 1;

  always @(negedge clk) begin
    if (go9 != '0) begin
      la9[n9]   <= 160'(addr9);
      lact9[n9] <= 16'(act9);
      lgo9[n9]  <= 16'(go9);
      lt9[n9]   <= gcyc;
      n9        <= n9 + 1;
    end
    if (go10 != '0) begin
      la10[n10]   <= 160'(addr10);
      lact10[n10] <= 16'(act10);
      lgo10[n10]  <= 16'(go10);
      n10         <= n10 + 1;
    end
    if (fin9) nf9 <= nf9 + 1;
    if (fin10) nf10 <= nf10 + 1;
  end

  task automatic check(input string tag, input logic [159:0] got, input logic [159:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    else n_pass++;
  endtask

  function automatic logic [159:0] exp_addr(input int as, input logic [14:0] b0, input int b);
    logic [159:0] v;
    v = '0;
    for (int k = 0; k < as; k++) begin
      int w;
      w = b * as + k;
      if (w < 144) v[k*15 +: 15] = 15'(int'(b0) + 2 * (w / 12) * 24 + 2 * (w % 12));
    end
    return v;
  endfunction

  function automatic logic [15:0] exp_mask(input int as, input int b);
    logic [15:0] m;
    m = '0;
    for (int k = 0; k < as; k++) if (b * as + k < 144) m[k] = 1'b1;
    return m;
  endfunction

  task automatic verify(input int sel, input string tag, input int s, input int nb,
                        input logic [14:0] b0);
    int as;
    as = (sel != 0) ? 10 : 9;
    for (int i = 0; i < nb; i++) begin
      check({tag, "_addr"}, (sel != 0) ? la10[s+i] : la9[s+i], exp_addr(as, b0, i));
      check({tag, "_act"}, 160'((sel != 0) ? lact10[s+i] : lact9[s+i]), 160'(exp_mask(as, i)));
      check({tag, "_go"}, 160'((sel != 0) ? lgo10[s+i] : lgo9[s+i]), 160'(exp_mask(as, i)));
    end
  endtask

  // Cycle 0 drives start; cycle 1 is the first ISSUE. Returns at the finish cycle or budget.
  task automatic run_dut(input int sel, input int budget, input int start2, input int abort_at,
                         input bit spur, output int cyc, output bit fin);
    cyc = 0;
    fin = 1'b0;
    while (!fin && cyc < budget) begin
      if (sel != 0) start10 = (cyc == 0) || (cyc == start2);
      else start9 = (cyc == 0) || (cyc == start2);
      abort = (cyc == abort_at);
      if (spur) extra9 = (go9 != '0) ? '1 : '0;
      @(negedge clk);
      cyc++;
      fin = (sel != 0) ? fin10 : fin9;
    end
    start9  = 1'b0;
    start10 = 1'b0;
    abort   = 1'b0;
    if (spur) extra9 = '0;
  endtask

  int s, f, cyc;
  bit fin;

  initial begin
    reset = 1'b0; start9 = 1'b0; start10 = 1'b0; abort = 1'b0; base = '0;
    extra9 = '0; extra10 = '0;
    for (int k = 0; k < 9; k++) lat9[k] = 3;
    for (int k = 0; k < 10; k++) lat10[k] = 3;
    repeat (3) @(negedge clk);
    check("rst_addr", 160'(addr9), 0);
    check("rst_act", 160'(act9), 0);
    check("rst_go", 160'(go9), 0);
    check("rst_busy", 160'(busy9), 0);
    check("rst_fin", 160'(fin9), 0);
    check("rst_act10", 160'(act10), 0);
    reset = 1'b1;
    @(negedge clk);

    // Test 1: 16 batches, 4-cycle period.
    s = n9; f = nf9;
    run_dut(0, 200, -1, -1, 1'b0, cyc, fin);
    check("t1_fin", 160'(fin), 1);
    check("t1_cycles", 160'(cyc), 65);
    @(negedge clk);
    check("t1_busy_after", 160'(busy9), 0);
    check("t1_fin_once", 160'(nf9 - f), 1);
    check("t1_nbatch", 160'(n9 - s), 16);
    check("t1_b1l0", 160'(la9[s+1][14:0]), 18);
    check("t1_b1l3", 160'(la9[s+1][59:45]), 48);
    verify(0, "t1", s, 16, 15'h0000);

    // Test 2: 10 lanes, partial last batch; constant done on lanes 4..9.
    for (int k = 0; k < 10; k++) lat10[k] = (k < 4) ? 5 : 1;
    extra10 = 10'h3F0;
    s = n10; f = nf10;
    run_dut(1, 300, -1, -1, 1'b0, cyc, fin);
    check("t2_fin", 160'(fin), 1);
    check("t2_cycles", 160'(cyc), 91);
    extra10 = '0;
    @(negedge clk);
    check("t2_busy_after", 160'(busy10), 0);
    check("t2_fin_once", 160'(nf10 - f), 1);
    check("t2_nbatch", 160'(n10 - s), 15);
    check("t2_last_act", 160'(lact10[s+14]), 16'h000F);
    check("t2_last_l3", 160'(la10[s+14][59:45]), 550);
    check("t2_last_l4", 160'(la10[s+14][74:60]), 0);
    check("t2_b0l9", 160'(la10[s][149:135]), 18);
    verify(1, "t2", s, 15, 15'h0000);

    // Test 3: staggered dones, lane 8 at 20 cycles; all-ones done during ISSUE.
    for (int k = 0; k < 9; k++) lat9[k] = (k == 8) ? 20 : 1 + k;
    s = n9; f = nf9;
    run_dut(0, 600, -1, -1, 1'b1, cyc, fin);
    check("t3_fin", 160'(fin), 1);
    check("t3_cycles", 160'(cyc), 337);
    @(negedge clk);
    check("t3_nbatch", 160'(n9 - s), 16);
    for (int b = 1; b < 16; b++) check("t3_period", 160'(lt9[s+b] - lt9[s+b-1]), 21);
    verify(0, "t3", s, 16, 15'h0000);

    // Test 4: address wrap, start while busy ignored.
    for (int k = 0; k < 9; k++) lat9[k] = 3;
    base = 15'h7FF0;
    s = n9; f = nf9;
    run_dut(0, 200, 30, -1, 1'b0, cyc, fin);
    check("t4_fin", 160'(fin), 1);
    check("t4_cycles", 160'(cyc), 65);
    repeat (4) @(negedge clk);
    check("t4_busy_after", 160'(busy9), 0);
    check("t4_fin_once", 160'(nf9 - f), 1);
    check("t4_nbatch", 160'(n9 - s), 16);
    check("t4_b0l0", 160'(la9[s][14:0]), 15'h7FF0);
    check("t4_b0l8", 160'(la9[s][134:120]), 0);
    check("t4_b1l3", 160'(la9[s+1][59:45]), 15'h0020);
    verify(0, "t4", s, 16, 15'h7FF0);

    // Test 5: abort in WAIT of batch 5, then a fresh run.
    base = 15'h0000;
    s = n9; f = nf9;
    run_dut(0, 24, -1, 23, 1'b0, cyc, fin);
    check("t5_no_fin", 160'(fin), 0);
    check("t5_busy", 160'(busy9), 0);
    check("t5_act", 160'(act9), 0);
    check("t5_go", 160'(go9), 0);
    check("t5_addr", 160'(addr9), 0);
    repeat (3) @(negedge clk);
    check("t5_fin_cnt", 160'(nf9 - f), 0);
    check("t5_nbatch", 160'(n9 - s), 6);
    base = 15'h0100;
    s = n9; f = nf9;
    run_dut(0, 200, -1, -1, 1'b0, cyc, fin);
    check("t5r_cycles", 160'(cyc), 65);
    @(negedge clk);
    check("t5r_fin_once", 160'(nf9 - f), 1);
    check("t5r_b0l0", 160'(la9[s][14:0]), 15'h0100);
    verify(0, "t5r", s, 16, 15'h0100);

    // Test 6: asynchronous reset in WAIT of batch 2, then a normal run.
    base = 15'h0000;
    s = n9; f = nf9;
    run_dut(0, 10, -1, -1, 1'b0, cyc, fin);
    check("t6_busy_pre", 160'(busy9), 1);
    check("t6_act_pre", 160'(act9), 9'h1FF);
    check("t6_go_pre", 160'(go9), 0);
    check("t6_addr_hold", 160'(addr9), exp_addr(9, 15'h0000, 2));
    #2 reset = 1'b0;
    #1;
    check("t6_busy", 160'(busy9), 0);
    check("t6_act", 160'(act9), 0);
    check("t6_addr", 160'(addr9), 0);
    check("t6_go", 160'(go9), 0);
    check("t6_fin", 160'(fin9), 0);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("t6_fin_cnt", 160'(nf9 - f), 0);
    s = n9; f = nf9;
    run_dut(0, 200, -1, -1, 1'b0, cyc, fin);
    check("t6r_cycles", 160'(cyc), 65);
    @(negedge clk);
    check("t6r_fin_once", 160'(nf9 - f), 1);
    check("t6r_nbatch", 160'(n9 - s), 16);
    verify(0, "t6r", s, 16, 15'h0000);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
